// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants, default modulus/mu pair and the per-stage sideband records.
package ntt_pkg;
    localparam int Q_W   = 28;
    localparam int TAG_W = 32;

    // 2^28 - 2^16 + 1, NTT-friendly prime; mu = floor(2^(2*Q_W) / q)
    localparam logic [Q_W-1:0] Q_DEFAULT  = 28'd268369921;
    localparam logic [63:0]    MU_FULL    = (64'd1 << (2*Q_W)) / 64'(Q_DEFAULT);
    localparam logic [Q_W:0]   MU_DEFAULT = MU_FULL[Q_W:0];

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } stage_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [Q_W-1:0]   data;
    } result_t;
endpackage

// File: rtl/mod_mul_barrett_corr.sv
// Final Barrett correction: folds r in [0,3q) into [0,q) with two parallel compare-subtracts.
module mod_mul_barrett_corr
    import ntt_pkg::*;
#(
    parameter int Q_W = ntt_pkg::Q_W
) (
    input  logic [Q_W+1:0] r,
    input  logic [Q_W-1:0] q,
    output logic [Q_W-1:0] res
);
    logic [Q_W+1:0] q1, q2, d1, d2;

    assign q1 = {2'b00, q};
    assign q2 = {1'b0, q, 1'b0};
    assign d1 = r - q1;
    assign d2 = r - q2;

    always_comb begin
        res = r[Q_W-1:0];
        if (r >= q2)
            res = d2[Q_W-1:0];
        else if (r >= q1)
            res = d1[Q_W-1:0];
    end
endmodule

// File: rtl/mod_mul_barrett.sv
// Pipelined Barrett modular multiplier, out = (a*b) mod q, with tag sideband and full-pipeline stall.
// Optional MOD_MUL_BARRETT_OUT_REG_EN: 2-entry output skid, latency 5, registered in_ready.
module mod_mul_barrett
    import ntt_pkg::*;
#(
    parameter int Q_W   = ntt_pkg::Q_W,
    parameter int TAG_W = ntt_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Q_W-1:0]   q,
    input  logic [Q_W:0]     mu,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   a,
    input  logic [Q_W-1:0]   b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   out,
    output logic [TAG_W-1:0] out_tag
);
    localparam int K      = Q_W;
    localparam int STAGES = 4;

    stage_t         meta_in;
    stage_t         meta_q [1:STAGES];
    logic           pipe_adv;

    logic [2*K-1:0] s1_z;
    logic [K+1:0]   s2_t, s2_zlo, s3_r;
    logic [K-1:0]   s4_q, s4_d;
    logic [K+1:0]   t_nxt, r_nxt;

    assign meta_in = '{valid: in_valid, tag: in_tag};

    // quotient estimate; only the low k+2 bits of z and t*q matter since r < 3q < 2^(k+2)
    assign t_nxt = (K+2)'(((2*K+2)'(s1_z[2*K-1:K-1]) * (2*K+2)'(mu)) >> (K+1));
    assign r_nxt = s2_zlo - (K+2)'((2*K+2)'(s2_t) * (2*K+2)'(q));

    mod_mul_barrett_corr #(.Q_W(K)) u_corr (
        .r   (s3_r),
        .q   (q),
        .res (s4_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_z   <= '0;
            s2_t   <= '0;
            s2_zlo <= '0;
            s3_r   <= '0;
            s4_q   <= '0;
            for (int i = 1; i <= STAGES; i++) meta_q[i] <= '0;
        end else if (pipe_adv) begin
            s1_z      <= (2*K)'(a) * (2*K)'(b);
            s2_t      <= t_nxt;
            s2_zlo    <= s1_z[K+1:0];
            s3_r      <= r_nxt;
            s4_q      <= s4_d;
            meta_q[1] <= meta_in;
            for (int i = 2; i <= STAGES; i++) meta_q[i] <= meta_q[i-1];
        end
    end

`ifdef MOD_MUL_BARRETT_OUT_REG_EN
    result_t    skid0, skid1, s4_res;
    logic [1:0] cnt, cnt_nxt;
    logic       skid_full, push, pop;

    // pipeline only moves while the skid has a free slot, so in_ready never sees out_ready
    assign pipe_adv = ~skid_full;
    assign s4_res   = '{tag: meta_q[STAGES].tag, data: s4_q};
    assign push     = pipe_adv & meta_q[STAGES].valid;
    assign pop      = out_valid & out_ready;
    assign cnt_nxt  = cnt + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid0     <= '0;
            skid1     <= '0;
            cnt       <= '0;
            skid_full <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            skid_full <= (cnt_nxt == 2'd2);
            if (pop) begin
                if (cnt == 2'd2)
                    skid0 <= skid1;
                else if (push)
                    skid0 <= s4_res;
            end else if (push) begin
                if (cnt == 2'd0)
                    skid0 <= s4_res;
                else
                    skid1 <= s4_res;
            end
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out       = skid0.data;
    assign out_tag   = skid0.tag;
`else
    assign out_valid = meta_q[STAGES].valid;
    assign out       = s4_q;
    assign out_tag   = meta_q[STAGES].tag;
    assign pipe_adv  = ~out_valid | out_ready;
`endif

    assign in_ready = pipe_adv;
endmodule

// File: tb/tb_mod_mul_barrett.sv
// Scoreboard bench for mod_mul_barrett; honours MOD_MUL_BARRETT_OUT_REG_EN for the expected latency.
module tb_mod_mul_barrett;
    localparam int QW    = 28;
    localparam int TW    = 32;
    localparam int NRAND = 10000;
    localparam logic [63:0] QV   = 64'd268369921;
    localparam logic [63:0] MU64 = (64'd1 << 56) / QV;
`ifdef MOD_MUL_BARRETT_OUT_REG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct { logic [QW-1:0] d; logic [TW-1:0] tag; } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [QW-1:0] q;
    logic [QW:0]   mu;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [QW-1:0] a, b, out;
    logic [TW-1:0] in_tag, out_tag;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mod_mul_barrett dut (
        .clk(clk), .rst_n(rst_n), .q(q), .mu(mu),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [QW-1:0] model(input logic [QW-1:0] x, input logic [QW-1:0] y);
        logic [63:0] p;
        p = (64'(x) * 64'(y)) % QV;
        return p[QW-1:0];
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out !== '0) begin failures++; $display("FAIL rst_out: got %0d want 0", out); end
        checks++; if (out_tag !== '0) begin failures++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL post_rst: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_latency();
        int lat = 1;
        @(negedge clk);
        out_ready = 1'b1; a = '0; b = QW'(12345); in_tag = 32'hA5A5_0001; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_accept: in_ready=%b want 1", in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        while (!out_valid && lat < 20) begin @(negedge clk); #1; lat++; end
        checks++; if (lat != LAT) begin failures++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
        checks++; if (out !== '0) begin failures++; $display("FAIL lat_out: got %0d want 0", out); end
        checks++; if (out_tag !== 32'hA5A5_0001) begin failures++; $display("FAIL lat_tag: got %h want a5a50001", out_tag); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_single: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [QW-1:0] va [3];
        logic [QW-1:0] vb [3];
        logic [QW-1:0] ve [3];
        int sent = 0, got = 0, cyc = 0;
        exp_t e;
        va[0] = QW'(2);          vb[0] = QW'(3);          ve[0] = QW'(6);
        va[1] = QW'(QV - 1);     vb[1] = QW'(2);          ve[1] = QW'(268369919);
        va[2] = QW'(QV - 1);     vb[2] = QW'(QV - 1);     ve[2] = QW'(1);
        while ((sent < 3 || got < 3) && cyc < 50) begin
            @(negedge clk); out_ready = 1'b1; #1; cyc++;
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL dir_extra: unexpected out=%0d", out); end
                else begin
                    e = sb.pop_front();
                    if (out !== e.d || out_tag !== e.tag) begin
                        failures++; $display("FAIL dir_data: got %0d/%h want %0d/%h", out, out_tag, e.d, e.tag);
                    end
                end
                got++;
            end
            if (sent < 3) begin
                a = va[sent]; b = vb[sent]; in_tag = 32'hD000 + 32'(sent); in_valid = 1'b1;
                if (in_ready) begin sb.push_back('{d: ve[sent], tag: in_tag}); sent++; end
            end else in_valid = 1'b0;
        end
        checks++; if (got != 3) begin failures++; $display("FAIL dir_count: got %0d want 3", got); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, gaps = 0, notrdy = 0, cyc = 0;
        bit need_new = 1'b1;
        exp_t e;
        while ((sent < NRAND || got < NRAND) && cyc < NRAND + 100) begin
            @(negedge clk); out_ready = 1'b1; #1; cyc++;
            if (got > 0 && got < NRAND && !out_valid) gaps++;
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL b2b_extra: unexpected out=%0d", out); end
                else begin
                    e = sb.pop_front();
                    if (out !== e.d || out_tag !== e.tag) begin
                        failures++; $display("FAIL b2b_data #%0d: got %0d/%h want %0d/%h", got, out, out_tag, e.d, e.tag);
                    end
                end
                got++;
            end
            if (sent < NRAND) begin
                if (need_new) begin
                    a = QW'($urandom_range(32'(QV - 1), 0));
                    b = QW'($urandom_range(32'(QV - 1), 0));
                    in_tag = $urandom; need_new = 1'b0;
                end
                in_valid = 1'b1;
                if (in_ready) begin sb.push_back('{d: model(a, b), tag: in_tag}); sent++; need_new = 1'b1; end
                else notrdy++;
            end else in_valid = 1'b0;
        end
        checks++; if (got != NRAND) begin failures++; $display("FAIL b2b_count: got %0d want %0d", got, NRAND); end
        checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
        checks++; if (notrdy != 0) begin failures++; $display("FAIL b2b_in_ready: low %0d cycles want 0", notrdy); end
    endtask

    task automatic test_stall();
        int sent = 0, got = 0, cyc = 0, stall_left = 0, stall_idx = 0, extra = 0;
        bit stalled = 1'b0;
        logic [QW-1:0] hold_d;
        logic [TW-1:0] hold_t;
        exp_t e;
`ifdef MOD_MUL_BARRETT_OUT_REG_EN
        logic r0;
`endif
        while ((sent < 6 || got < 6) && cyc < 60) begin
            @(negedge clk); #1; cyc++;
            if (out_valid && !stalled) begin
                stalled = 1'b1; stall_left = 3; stall_idx = 0; hold_d = out; hold_t = out_tag;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                if (stall_idx > 0) begin
                    checks++;
                    if (out_valid !== 1'b1 || out !== hold_d || out_tag !== hold_t) begin
                        failures++; $display("FAIL stall_hold: got %b/%0d/%h want 1/%0d/%h", out_valid, out, out_tag, hold_d, hold_t);
                    end
                end
`ifdef MOD_MUL_BARRETT_OUT_REG_EN
                if (stall_idx > 0) begin
                    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                end
                r0 = in_ready; out_ready = 1'b1; #1;
                checks++; if (in_ready !== r0) begin failures++; $display("FAIL in_ready_comb: got %b want %b", in_ready, r0); end
                out_ready = 1'b0; #1;
`else
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
`endif
                stall_left--; stall_idx++;
            end else if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL stall_dup: unexpected out=%0d tag=%h", out, out_tag); end
                else begin
                    e = sb.pop_front();
                    if (out !== e.d || out_tag !== e.tag) begin
                        failures++; $display("FAIL stall_data: got %0d/%h want %0d/%h", out, out_tag, e.d, e.tag);
                    end
                end
                got++;
            end
            if (sent < 6) begin
                a = QW'(sent * 1000003 + 7); b = QW'(sent * 77 + 3); in_tag = 32'h100 + 32'(sent); in_valid = 1'b1;
                if (in_ready) begin sb.push_back('{d: model(a, b), tag: in_tag}); sent++; end
            end else in_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (6) begin @(negedge clk); #1; if (out_valid) extra++; end
        checks++; if (got != 6) begin failures++; $display("FAIL stall_count: got %0d want 6", got); end
        checks++; if (extra != 0 || sb.size() != 0) begin
            failures++; $display("FAIL stall_leftover: extra=%0d pending=%0d want 0/0", extra, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        int sent = 0, cyc = 0, stale = 0, lat = 1;
        out_ready = 1'b0;
        while (cyc < 20) begin
            @(negedge clk); #1; cyc++;
            if (out_valid) break;
            if (sent < 3) begin
                a = QW'(sent + 11); b = QW'(sent + 5); in_tag = 32'hBAD0 + 32'(sent); in_valid = 1'b1;
                if (in_ready) sent++;
            end else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_fill: out_valid=%b want 1", out_valid); end
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async: out_valid=%b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1 || out !== '0) begin
            failures++; $display("FAIL midrst_state: in_ready=%b out=%0d want 1/0", in_ready, out);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; sb.delete();
        repeat (8) begin @(negedge clk); #1; if (out_valid) stale++; end
        checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale: got %0d outputs want 0", stale); end
        @(negedge clk);
        a = QW'(2); b = QW'(3); in_tag = 32'hC0DE_0005; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        while (!out_valid && lat < 20) begin @(negedge clk); #1; lat++; end
        checks++; if (lat != LAT) begin failures++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out !== QW'(6) || out_tag !== 32'hC0DE_0005) begin
            failures++; $display("FAIL midrst_data: got %0d/%h want 6/c0de0005", out, out_tag);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; in_tag = '0;
        q = QW'(QV); mu = (QW+1)'(MU64);
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
